// File: rtl/bottleneck_act_stream.sv
// Streaming bottleneck stage: per-channel saturating bias add plus a selectable
// activation, one element per valid/ready handshake, with frame-end tagging.
module bottleneck_act_stream #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned CHANNELS     = 256,
    parameter int unsigned FRAME_PIXELS = 784,
    parameter int unsigned LEAKY_SHIFT  = 3,
    parameter logic [DATA_WIDTH-1:0] CLIP_VALUE = 16'h0600
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic                        bias_wr_en,
    input  logic [$clog2(CHANNELS)-1:0] bias_wr_addr,
    input  logic [DATA_WIDTH-1:0]       bias_wr_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic                        m_last,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 sat_count
);

    localparam int unsigned TOTAL  = FRAME_PIXELS * CHANNELS;
    localparam int unsigned CH_W   = $clog2(CHANNELS);
    localparam int unsigned ELEM_W = $clog2(TOTAL);
    localparam int unsigned SUM_W  = DATA_WIDTH + 1;

    localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [ELEM_W-1:0]     elem_q, elem_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [15:0]           sat_q, sat_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [DATA_WIDTH-1:0] bias_q [CHANNELS];

    logic                  accept;
    logic                  last_elem;
    logic                  ovf;
    logic [SUM_W-1:0]      sum;
    logic [DATA_WIDTH-1:0] sat_x;
    logic [DATA_WIDTH-1:0] act;

    // Output slot is free when empty or being drained this cycle
    assign s_ready   = (state_q == S_RUN) && (!m_valid_q || m_ready);
    assign accept    = s_valid && s_ready;
    assign last_elem = (elem_q == ELEM_W'(TOTAL - 1));

    // Sign-extended add, clamp on overflow, then activation
    always_comb begin
        sum   = {bias_q[ch_q][DATA_WIDTH-1], bias_q[ch_q]} + {s_data[DATA_WIDTH-1], s_data};
        ovf   = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
        sat_x = sum[DATA_WIDTH-1:0];
        if (ovf) begin
            sat_x = sum[DATA_WIDTH] ? SMIN : SMAX;
        end
        act = sat_x;
        case (mode_q)
            2'd1: if (sat_x[DATA_WIDTH-1]) act = '0;
            2'd2: if (sat_x[DATA_WIDTH-1]) act = DATA_WIDTH'($signed(sat_x) >>> LEAKY_SHIFT);
            2'd3: begin
                if (sat_x[DATA_WIDTH-1]) begin
                    act = '0;
                end else if ($signed(sat_x) > $signed(CLIP_VALUE)) begin
                    act = CLIP_VALUE;
                end
            end
            default: ;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        elem_d    = elem_q;
        ch_d      = ch_q;
        sat_d     = sat_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    elem_d  = '0;
                    ch_d    = '0;
                    sat_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    elem_d = last_elem ? '0 : elem_q + ELEM_W'(1);
                    ch_d   = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + CH_W'(1);
                    if (ovf && (sat_q != 16'hFFFF)) begin
                        sat_d = sat_q + 16'd1;
                    end
                    if (last_elem) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!m_valid_q || m_ready) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = act;
            m_last_d  = last_elem;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            elem_q    <= '0;
            ch_q      <= '0;
            sat_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            elem_q    <= elem_d;
            ch_q      <= ch_d;
            sat_q     <= sat_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Bias table is writable only while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                bias_q[i] <= '0;
            end
        end else if ((state_q == S_IDLE) && bias_wr_en) begin
            bias_q[bias_wr_addr] <= bias_wr_data;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sat_count = sat_q;

endmodule

// File: tb/tb_bottleneck_act_stream.sv
// Directed bench for bottleneck_act_stream with 4 channels x 2 pixels per frame.
module tb_bottleneck_act_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        bias_wr_en = 1'b0;
    logic [1:0]  bias_wr_addr = 2'd0;
    logic [15:0] bias_wr_data = 16'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = 16'd0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] din  [8];
    logic [15:0] dexp [8];

    bottleneck_act_stream #(
        .DATA_WIDTH(16), .CHANNELS(4), .FRAME_PIXELS(2), .LEAKY_SHIFT(3), .CLIP_VALUE(16'h0600)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one sample, wait for acceptance, then check the registered result
    task automatic xfer(input logic [15:0] d, input logic [15:0] e, input logic l, input int idx);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        m_ready = 1'b1;
        #1;
        n = 0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("accept_wait%0d", idx), 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("m_valid%0d", idx), 32'(m_valid), 32'd1);
        chk($sformatf("m_data%0d", idx), 32'(m_data), 32'(e));
        chk($sformatf("m_last%0d", idx), 32'(m_last), 32'(l));
    endtask

    task automatic bias_write(input logic [1:0] a, input logic [15:0] v);
        @(negedge clk);
        bias_wr_en   = 1'b1;
        bias_wr_addr = a;
        bias_wr_data = v;
        @(negedge clk);
        bias_wr_en   = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] md, input logic we, input logic [1:0] a,
                               input logic [15:0] v);
        @(negedge clk);
        start        = 1'b1;
        mode         = md;
        bias_wr_en   = we;
        bias_wr_addr = a;
        bias_wr_data = v;
        @(negedge clk);
        start      = 1'b0;
        bias_wr_en = 1'b0;
        mode       = ~md;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic do_frame(input int fid);
        for (int i = 0; i < 8; i++) begin
            xfer(din[i], dexp[i], (i == 7), fid * 10 + i);
            if (fid == 0 && i == 2) begin
                m_ready = 1'b0;
                s_valid = 1'b1;
                s_data  = din[3];
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_s_ready", 32'(s_ready), 32'd0);
                    chk("stall_m_data", 32'(m_data), 32'h7FFF);
                    chk("stall_m_valid", 32'(m_valid), 32'd1);
                end
            end
            if (fid == 1 && i == 1) begin
                chk("sat_two", 32'(sat_count), 32'd2);
                start        = 1'b1;
                bias_wr_en   = 1'b1;
                bias_wr_addr = 2'd0;
                bias_wr_data = 16'h0100;
                @(negedge clk);
                start      = 1'b0;
                bias_wr_en = 1'b0;
                chk("busy_run_start", 32'(busy), 32'd1);
            end
            if (fid == 4 && i == 2) begin
                rst = 1'b0;
                #1;
                chk("rst_m_valid", 32'(m_valid), 32'd0);
                chk("rst_s_ready", 32'(s_ready), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_sat", 32'(sat_count), 32'd0);
                chk("rst_m_data", 32'(m_data), 32'd0);
                @(negedge clk);
                chk("rst_no_done", 32'(done), 32'd0);
                rst = 1'b1;
                @(negedge clk);
                chk("post_rst_done", 32'(done), 32'd0);
                return;
            end
        end
        chk("drain_done", 32'(done), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_s_ready", 32'(s_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sat", 32'(sat_count), 32'd0);
        chk("reset_m_last", 32'(m_last), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ReLU, zero biases, with a mid-frame downstream stall
        din  = '{16'h0100, 16'hFF00, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h0200, 16'h0000};
        dexp = '{16'h0100, 16'h0000, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 16'h0200, 16'h0000};
        start_frame(2'd1, 1'b0, 2'd0, 16'h0000);
        do_frame(0);
        chk("sat_frame0", 32'(sat_count), 32'd0);

        // Pass-through with saturating biases; start and bias write in RUN ignored
        bias_write(2'd0, 16'h7000);
        bias_write(2'd1, 16'h8000);
        din  = '{16'h2000, 16'h9000, 16'h1234, 16'hFF00, 16'h0001, 16'h0001, 16'h8000, 16'h7FFF};
        dexp = '{16'h7FFF, 16'h8000, 16'h1234, 16'hFF00, 16'h7001, 16'h8001, 16'h8000, 16'h7FFF};
        start_frame(2'd0, 1'b0, 2'd0, 16'h0000);
        do_frame(1);
        chk("sat_frame1", 32'(sat_count), 32'd2);

        // Leaky ReLU; ch0 must still carry 0x7000
        din  = '{16'h9100, 16'h7F00, 16'hFF00, 16'hFFF9, 16'h8FFF, 16'h8000, 16'h0100, 16'h8000};
        dexp = '{16'h0100, 16'hFFE0, 16'hFFE0, 16'hFFFF, 16'hFFFF, 16'hF000, 16'h0100, 16'hF000};
        start_frame(2'd2, 1'b0, 2'd0, 16'h0000);
        do_frame(2);
        chk("sat_frame2", 32'(sat_count), 32'd1);

        // Clipped ReLU; bias[2] written in the same cycle as start
        din  = '{16'h9700, 16'h7FFF, 16'h0200, 16'hFF00, 16'h9600, 16'h7FFF, 16'h0500, 16'h0601};
        dexp = '{16'h0600, 16'h0000, 16'h0300, 16'h0000, 16'h0600, 16'h0000, 16'h0600, 16'h0600};
        start_frame(2'd3, 1'b1, 2'd2, 16'h0100);
        do_frame(3);
        chk("sat_frame3", 32'(sat_count), 32'd0);

        // Reset mid-frame, then a clean restart with cleared biases
        din  = '{16'h0100, 16'h0200, 16'h0300, 16'hFFFF, 16'h0010, 16'h8000, 16'h0020, 16'h0030};
        dexp = '{16'h7100, 16'h0000, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        start_frame(2'd1, 1'b0, 2'd0, 16'h0000);
        do_frame(4);
        dexp = '{16'h0100, 16'h0200, 16'h0300, 16'h0000, 16'h0010, 16'h0000, 16'h0020, 16'h0030};
        start_frame(2'd1, 1'b0, 2'd0, 16'h0000);
        do_frame(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
